// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 self-test controller.
package c17_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_APPLY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int unsigned LFSR_W    = 5;
  localparam int unsigned MISR_W    = 8;
  localparam logic [7:0]  MISR_POLY = 8'h1D;

  // Fibonacci taps for x^5 + x^3 + 1
  localparam int unsigned LFSR_TAP_HI = 4;
  localparam int unsigned LFSR_TAP_LO = 2;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register with synchronous clear and capture enable.
module bist_misr #(
  parameter int unsigned        WIDTH = 8,
  parameter logic [WIDTH-1:0]   POLY  = 8'h1D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sig
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ din;
    end
  end

endmodule

// File: rtl/c17_bist_ctrl.sv
// LFSR-driven BIST around the c17 netlist with MISR compaction and golden compare.
// Optional FI port for response fault injection: define C17_BIST_FAULT_INJ_EN.
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int unsigned        PAT_COUNT  = 31,
  parameter logic [LFSR_W-1:0]  LFSR_SEED  = 5'h01,
  parameter logic [MISR_W-1:0]  GOLDEN_SIG = 8'h00
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
`ifdef C17_BIST_FAULT_INJ_EN
  input  logic              FI,
`endif
  output logic              I1,
  output logic              I2,
  output logic              I3,
  output logic              I6,
  output logic              I7,
  input  logic              O22,
  input  logic              O23,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [MISR_W-1:0] SIGNATURE,
  output logic [4:0]        PAT_IDX
);

  localparam logic [4:0] PAT_LAST = 5'(PAT_COUNT);

  state_t             state, state_nx;
  logic [LFSR_W-1:0]  lfsr;
  logic [4:0]         pat_idx;
  logic               load;
  logic               capture;
  logic               last_pat;
  logic               o22_eff;
  logic [MISR_W-1:0]  misr_din;
  logic [MISR_W-1:0]  sig;

  assign last_pat = (pat_idx + 5'd1) == PAT_LAST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (START) state_nx = ST_APPLY;
      ST_APPLY:   state_nx = ST_CAPTURE;
      ST_CAPTURE: state_nx = last_pat ? ST_DONE : ST_APPLY;
      ST_DONE:    if (START) state_nx = ST_APPLY;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    load    = START && ((state == ST_IDLE) || (state == ST_DONE));
    capture = (state == ST_CAPTURE);
    BUSY    = (state == ST_APPLY) || (state == ST_CAPTURE);
    DONE    = (state == ST_DONE);
    PASS    = (state == ST_DONE) && (sig == GOLDEN_SIG);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lfsr    <= '0;
      pat_idx <= '0;
    end else if (load) begin
      lfsr    <= LFSR_SEED;
      pat_idx <= '0;
    end else if (capture) begin
      lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_TAP_HI] ^ lfsr[LFSR_TAP_LO]};
      if (pat_idx != PAT_LAST) pat_idx <= pat_idx + 5'd1;
    end
  end

`ifdef C17_BIST_FAULT_INJ_EN
  // FI only matters while capturing; the MISR ignores din otherwise
  assign o22_eff = O22 ^ FI;
`else
  assign o22_eff = O22;
`endif

  assign misr_din = {{(MISR_W-2){1'b0}}, O23, o22_eff};

  bist_misr #(
    .WIDTH (MISR_W),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clk (CLK),
    .rst (RST),
    .clr (load),
    .en  (capture),
    .din (misr_din),
    .sig (sig)
  );

  assign {I1, I2, I3, I6, I7} = lfsr;
  assign SIGNATURE = sig;
  assign PAT_IDX   = pat_idx;

endmodule
